// File: rtl/neuron_mac_pipe.sv
// neuron_mac_pipe: loadable-weight MAC neuron with saturating accumulate, bias add and linear/ReLU output.
// Optional macro NEURON_SAT_CNT_EN adds a sticky saturation-event counter on sat_count_o.
module neuron_mac_pipe #(
    parameter int unsigned LAYER_NO   = 2,
    parameter int unsigned NEURON_NO  = 0,
    parameter int unsigned NUM_WEIGHT = 30,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned INT_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           cfg_layer_i,
    input  logic [31:0]           cfg_neuron_i,
    input  logic                  weight_valid_i,
    input  logic [DATA_WIDTH-1:0] weight_value_i,
    input  logic                  bias_valid_i,
    input  logic [DATA_WIDTH-1:0] bias_value_i,
    input  logic                  act_mode_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
`ifdef NEURON_SAT_CNT_EN
    output logic [15:0]           sat_count_o,
`endif
    output logic                  weights_loaded_o
);

    localparam int unsigned FRAC  = DATA_WIDTH - INT_WIDTH;
    localparam int unsigned ACC_W = 2 * DATA_WIDTH;
    localparam int unsigned PTR_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_WEIGHT + 1);

    localparam logic [ACC_W-1:0]      ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]      ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        rcnt_q, rcnt_d;
    logic                    dcnt_q, dcnt_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic                    loaded_q, loaded_d;
    logic [DATA_WIDTH-1:0]   bias_q, bias_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, in_ready_q, busy_q;
    logic                    in_ready_d;
    logic signed [DATA_WIDTH-1:0] x_q, w_q;
    logic signed [ACC_W-1:0] prod_q, prod_d;
    logic                    v1_q, v2_q;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_WEIGHT];

    logic                    match, accept, mem_we, sat_evt;
    logic [ACC_W-1:0]        acc_sum, acc_sat, bias_ext, bias_sum, bias_sat;
    logic                    acc_ovf, bias_ovf, conv_clamp;
    logic [DATA_WIDTH-1:0]   conv_res, conv_val, act_val;
    logic [INT_WIDTH-1:0]    conv_hi;

    assign match  = (cfg_layer_i == 32'(LAYER_NO)) && (cfg_neuron_i == 32'(NEURON_NO));
    assign accept = in_valid_i && in_ready_q;

    // Saturating adders for the MAC and the bias stage
    assign prod_d   = ACC_W'(x_q) * ACC_W'(w_q);
    assign acc_sum  = acc_q + prod_q;
    assign acc_ovf  = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign acc_sat  = acc_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : acc_sum;
    assign bias_ext = {{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q} << FRAC;
    assign bias_sum = acc_q + bias_ext;
    assign bias_ovf = (acc_q[ACC_W-1] == bias_ext[ACC_W-1]) && (bias_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign bias_sat = bias_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : bias_sum;

    // Narrow the Q(2I).(2F) accumulator back to the I.F output format
    assign conv_res   = bias_sat[ACC_W-1-INT_WIDTH -: DATA_WIDTH];
    assign conv_hi    = bias_sat[ACC_W-1 -: INT_WIDTH];
    assign conv_clamp = conv_hi != {INT_WIDTH{conv_res[DATA_WIDTH-1]}};
    assign conv_val   = conv_clamp ? (bias_sat[ACC_W-1] ? OUT_MIN : OUT_MAX) : conv_res;
    assign act_val    = (act_mode_i && bias_sat[ACC_W-1]) ? '0 : conv_val;

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        dcnt_d     = dcnt_q;
        wptr_d     = wptr_q;
        loaded_d   = loaded_q;
        bias_d     = bias_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        mem_we     = 1'b0;
        sat_evt    = 1'b0;

        if (v2_q) begin
            acc_d   = acc_sat;
            sat_evt = acc_ovf;
        end

        case (state_q)
            IDLE: begin
                if (weight_valid_i && match) begin
                    mem_we = 1'b1;
                    if (wptr_q == PTR_W'(NUM_WEIGHT - 1)) begin
                        wptr_d   = '0;
                        loaded_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + PTR_W'(1);
                    end
                end
                if (bias_valid_i && match) bias_d = bias_value_i;
                if (accept) begin
                    acc_d   = '0;
                    rcnt_d  = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                    if (rcnt_q + CNT_W'(1) == CNT_W'(NUM_WEIGHT)) begin
                        state_d = DRAIN;
                        dcnt_d  = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q) state_d = BIAS;
                else        dcnt_d  = 1'b1;
            end
            BIAS: begin
                acc_d      = bias_sat;
                out_data_d = act_val;
                sat_evt    = sat_evt | bias_ovf | conv_clamp;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = loaded_d && ((state_d == IDLE) ||
                                  ((state_d == ACCUM) && (rcnt_d < CNT_W'(NUM_WEIGHT))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            dcnt_q      <= 1'b0;
            wptr_q      <= '0;
            loaded_q    <= 1'b0;
            bias_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            dcnt_q      <= dcnt_d;
            wptr_q      <= wptr_d;
            loaded_q    <= loaded_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= (state_d == OUT);
            in_ready_q  <= in_ready_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Operand fetch and product stages of the MAC pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            w_q    <= '0;
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= in_data_i;
                w_q <= mem_q[PTR_W'(rcnt_q)];
            end
            prod_q <= prod_d;
            v1_q   <= accept;
            v2_q   <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wptr_q] <= weight_value_i;
    end

`ifdef NEURON_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                sat_cnt_q <= '0;
        else if (sat_evt && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_count_o = sat_cnt_q;
`else
    logic unused_sat_evt;
    assign unused_sat_evt = sat_evt;
`endif

    assign in_ready_o       = in_ready_q;
    assign out_data_o       = out_data_q;
    assign out_valid_o      = out_valid_q;
    assign busy_o           = busy_q;
    assign weights_loaded_o = loaded_q;

endmodule
